// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store data-memory responder with programmable latency
// Optional DMEM_PERF_CNT_EN adds saturating rd_count/wr_count for successful accesses.
module dmem_responder #(
    parameter int DEPTH   = 40,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        accept;
    logic        access;
    logic        addr_err;
    logic [IW-1:0] widx;
    logic [31:0] rd_word;
    logic [31:0] mem_rd [DEPTH];

    assign widx     = cap_addr[IW+1:2];
    // Full-width compare so high address bits can never alias into the array
    assign addr_err = (cap_addr[1:0] != 2'b00) || (cap_addr >= 32'(DEPTH * 4));
    assign accept   = (state == IDLE) && req_valid;
    assign access   = (state == WAIT) && (cnt == 4'd0);

    // Sample table is the parabola i*(20-i); storage is deliberately not reset
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [31:0] word = (i <= 20) ? 32'(i * (20 - i)) : 32'd0;
        always_ff @(posedge clk) begin
            if (access && !addr_err && cap_we && (widx == IW'(i)))
                word <= cap_wdata;
        end
        assign mem_rd[i] = word;
    end

    always_comb begin
        rd_word = 32'd0;
        if (32'(widx) < DEPTH)
            rd_word = mem_rd[widx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && reset;
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                rsp_err   <= addr_err;
                rsp_rdata <= (addr_err || cap_we) ? 32'd0 : rd_word;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (access && !addr_err) begin
            if (cap_we && (wr_count != 16'hFFFF))
                wr_count <= wr_count + 16'd1;
            if (!cap_we && (rd_count != 16'hFFFF))
                rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table-driven scoreboard bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 40;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_PERF_CNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_PERF_CNT_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];
    int total = 0;
    int bad = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, " unexpected response"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, " rdata"}, rsp_rdata, e.rdata);
            check({name, " err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    task automatic push_exp(input logic we, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
        if (!err) begin
            if (we) exp_wr++;
            else    exp_rd++;
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input string name);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        push_exp(we, exp_rdata, exp_err);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(LAT));
        pop_compare(name);
        @(negedge clk);
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, 32'h28,       32'h0,        32'd100,      1'b0};
        vecs[1]  = '{1'b0, 32'h00,       32'h0,        32'd0,        1'b0};
        vecs[2]  = '{1'b0, 32'h50,       32'h0,        32'd0,        1'b0};
        vecs[3]  = '{1'b0, 32'h4C,       32'h0,        32'd19,       1'b0};
        vecs[4]  = '{1'b1, 32'h0C,       32'hDEADBEEF, 32'd0,        1'b0};
        vecs[5]  = '{1'b0, 32'h0C,       32'h0,        32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'h10,       32'h0,        32'd64,       1'b0};
        vecs[7]  = '{1'b0, 32'h06,       32'h0,        32'd0,        1'b1};
        vecs[8]  = '{1'b1, 32'h05,       32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[9]  = '{1'b0, 32'h04,       32'h0,        32'd19,       1'b0};
        vecs[10] = '{1'b0, 32'hA0,       32'h0,        32'd0,        1'b1};
        vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'd0,        1'b1};
        vecs[12] = '{1'b1, 32'h9C,       32'hA5A5A5A5, 32'd0,        1'b0};
        vecs[13] = '{1'b0, 32'h9C,       32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[14] = '{1'b0, 32'h9F,       32'h0,        32'd0,        1'b1};
        vecs[15] = '{1'b0, 32'h20,       32'h0,        32'd96,       1'b0};

        // reset state
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        #1;
        check("post-rst req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                    vecs[i].exp_err, $sformatf("vec%0d", i));

        // backpressure with an ignored request during the stall
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h24;
        push_exp(1'b0, 32'd99, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 32'h00;
                req_wdata = 32'h00000BAD;
            end
            @(negedge clk);
            check($sformatf("bp hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp hold%0d rdata", i), rsp_rdata, 32'd99);
            check($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        pop_compare("bp");
        @(negedge clk);
        check("bp after rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp after req_ready", 32'(req_ready), 32'd1);
        run_txn(1'b0, 32'h00, 32'h0, 32'd0, 1'b0, "bp ignored store");

        // reset while a store is waiting for its access edge
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h00;
        req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst req_ready", 32'(req_ready), 32'd0);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst rsp_rdata", rsp_rdata, 32'd0);
        check("midrst rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("midrst no response", 32'(n), 32'd0);
        run_txn(1'b0, 32'h00, 32'h0, 32'd0, 1'b0, "midrst discarded store");
        run_txn(1'b0, 32'h28, 32'h0, 32'd100, 1'b0, "perf load2");
        run_txn(1'b0, 32'h2C, 32'h0, 32'd99, 1'b0, "perf load3");
        run_txn(1'b1, 32'h30, 32'h1, 32'd0, 1'b0, "perf store1");
        run_txn(1'b1, 32'h34, 32'h2, 32'd0, 1'b0, "perf store2");
        run_txn(1'b0, 32'h31, 32'h0, 32'd0, 1'b1, "perf bad load");
        run_txn(1'b0, 32'h30, 32'h0, 32'd1, 1'b0, "perf readback");

`ifdef DMEM_PERF_CNT_EN
        check("rd_count", 32'(rd_count), 32'(exp_rd));
        check("wr_count", 32'(wr_count), 32'(exp_wr));
`endif
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests issued by the pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel.
- Holds a DEPTH x 32-bit word array preloaded with the 21-entry sample table.
- Provides a programmable access latency, so the core can be exercised against a non-zero-wait-state memory.
- Allows one outstanding transaction at a time.

Parameters:
- DEPTH, 40: number of 32-bit words; valid byte addresses are 0 to DEPTH*4-1.
- LATENCY, 2: cycles from request acceptance to response valid; legal range 1 to 15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index = req_addr >> 2.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset values: req_ready=0 while reset=0 and 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM in IDLE; wait counter cleared.
- Memory array is not cleared by reset. Initial contents: words 0..20 = 0,19,36,51,64,75,84,91,96,99,100,99,96,91,84,75,64,51,36,19,0. Words 21..DEPTH-1 = 0.
- FSM has three states:
  - IDLE: req_ready=1. Accept when req_valid=1 at a rising edge. On acceptance, capture we/addr/wdata, load the counter with LATENCY-1, and go to WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle. At the edge where counter=0, perform the access, register the response, and go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1 at an edge; then go to IDLE with rsp_valid=0.
- Latency and throughput:
  - Acceptance at edge T gives rsp_valid=1 after edge T+LATENCY.
  - With rsp_ready tied to 1, back-to-back requests are accepted every LATENCY+2 cycles.
- Error detection, evaluated on the captured address:
  - Misaligned: addr[1:0] != 0.
  - Out of range: addr >= DEPTH*4, using a full 32-bit compare with no wrap or aliasing.
  - On error: rsp_err=1, rsp_rdata=0, and the memory is not written.
- Store commits at the access edge (end of WAIT), never at acceptance. The store response carries rsp_rdata=0 and rsp_err=0.
- Load samples the array at the access edge. Because only one transaction is outstanding, a load after a store always returns the stored data.
- req_* inputs are ignored outside IDLE. req_valid dropping after acceptance has no effect.
- Reset mid-transaction (WAIT or RESP): the transaction is aborted, a store still in WAIT is discarded, and all outputs take their reset values.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0], reset to 0.
  - Each increments by 1 at the access edge of a successful (rsp_err=0) load or store respectively.
  - Each saturates at 0xFFFF.
  - Both ignore rsp_ready stalls.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Load from req_addr=0x28 with LATENCY=2 and rsp_ready=1 -> rsp_valid rises 2 cycles after acceptance, rsp_rdata=100, rsp_err=0.
2. Store 0xDEADBEEF to 0x0C, then load 0x0C -> store response rdata=0, err=0; load returns 0xDEADBEEF; a load of 0x10 still returns 64.
3. Load 0x06 and store 0xFFFFFFFF to 0x04 with address 0x05 -> both responses rsp_err=1, rdata=0; a subsequent load of 0x04 returns 19. Load 0xA0 (word 40, DEPTH=40) -> rsp_err=1.
4. Backpressure: load 0x24, hold rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_rdata=99 stable throughout, req_ready=0; a second req_valid is ignored; accepted only after the handshake and IDLE return.
5. Reset pulse low while a store of 0x12345678 to 0x00 is in WAIT -> outputs return to reset values, no response is produced, and a later load of 0x00 returns 0.
6. With DMEM_PERF_CNT_EN: 3 good loads, 2 good stores, 1 erroneous load -> rd_count=3, wr_count=2.
